registers_memory: RTL and testbench
===================================

Name: registers_memory

Overview:
- General-purpose register file for the instruction-decode stage of the pipelined CPU.
- Two combinational read ports supply the instruction's source operands.
- One synchronous write port accepts write-back results.
- Default configuration: 32 registers × 32 bits.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of each register address; depth = 2**ADDR_WIDTH (32 registers).

Ports:
- clk  input  1  system clock; all writes happen on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- wr_en  input  1  write enable; when high, a write occurs at the next rising clk edge.
- w_addr  input  ADDR_WIDTH  write register index.
- w_data  input  DATA_WIDTH  write data.
- r_addr1  input  ADDR_WIDTH  read port 1 register index.
- r_addr2  input  ADDR_WIDTH  read port 2 register index.
- r_data1  output  DATA_WIDTH  contents of register r_addr1.
- r_data2  output  DATA_WIDTH  contents of register r_addr2.

Behaviour:
- Storage: 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Reset:
  - rst_n low clears all registers to 0 immediately, independent of clk.
  - While rst_n is low, r_data1 and r_data2 read 0 for every address and writes are ignored.
  - Release of rst_n needs no synchronizer inside this block; release is synchronized by the system.
- Write:
  - On a rising clk edge with rst_n high and wr_en high, register[w_addr] <= w_data.
  - wr_en low: no register changes.
  - Only one write port, so no write-write conflict is possible.
- Read:
  - Purely combinational; r_dataN = register[r_addrN] with no clock latency.
  - Both ports are independent and may address the same register at once; both outputs are then identical.
- Write-to-read bypass:
  - If wr_en is high and w_addr equals r_addrN (and rst_n is high), r_dataN shows w_data combinationally in the same cycle.
  - This lets decode see a value being written back in that cycle.
  - After the edge, the stored value gives the same result.
- Any X/Z-free address in 0..2**ADDR_WIDTH-1 is legal; there is no out-of-range case because depth equals the full address space.
- No other state: no pipeline registers, no status outputs.

Optional Feature:
- Macro: REGISTERS_MEMORY_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to 0: writes to address 0 are discarded.
  - Reads of address 0 always return 0, including via the bypass path.
- Undefined: register 0 is an ordinary read/write register like all others.

Test Plan:
- Reset: pre-load r5=32'hDEADBEEF, assert rst_n=0 mid-cycle -> r_data1 (r_addr1=5) drops to 0 immediately; later reads of every address return 0.
- Basic write/read: wr_en=1, w_addr=1, w_data=50 for one edge, then wr_en=0; r_addr2=1 -> r_data2=50. Same with w_addr=2, w_data=100 and w_addr=3, w_data=200; then r_addr1=2, r_addr2=3 -> r_data1=100, r_data2=200.
- Register 0: wr_en=1, w_addr=0, w_data=25, then read r_addr1=0:
  - r_data1=25 without the macro.
  - r_data1=0 with REGISTERS_MEMORY_ZERO_REG_EN defined, including during the write cycle.
- Write disabled: wr_en=0, w_addr=3, w_data=7 across several edges -> r3 keeps 200.
- Bypass: r_addr1=4, then drive wr_en=1, w_addr=4, w_data=32'h12345678 before the edge -> r_data1=32'h12345678 before the edge and it persists after.
- Dual port same address: r_addr1=r_addr2=2 -> both outputs 100; random write/read sequence checked against a 32-entry reference array.

Source files
------------

// File: rtl/registers_memory.sv
// registers_memory: general-purpose register file for the decode stage.
// Two combinational read ports, one synchronous write port, and a
// write-to-read bypass so decode sees a value in the cycle it is written back.
// Optional build macro: REGISTERS_MEMORY_ZERO_REG_EN -- when defined,
// register 0 is hardwired to zero (writes discarded, reads return 0).
module registers_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr1,
  input  logic [ADDR_WIDTH-1:0] r_addr2,
  output logic [DATA_WIDTH-1:0] r_data1,
  output logic [DATA_WIDTH-1:0] r_data2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGISTERS_MEMORY_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_ok_s;

  // Qualify the write: a hardwired register 0 swallows writes to address 0.
  always_comb begin
    wr_ok_s = 1'b0;
    if (wr_en && !(ZERO_REG && (w_addr == '0))) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Next-state of the array: only the addressed entry can change.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_ok_s) begin
      regs_d[w_addr] = w_data;
    end else begin
      regs_d[w_addr] = regs_q[w_addr];
    end
  end

  // Storage: cleared asynchronously by rst_n, updated on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1: zero in reset, hardwired zero, bypass, then stored value.
  always_comb begin
    r_data1 = '0;
    if (!rst_n) begin
      r_data1 = '0;
    end else if (ZERO_REG && (r_addr1 == '0)) begin
      r_data1 = '0;
    end else if (wr_en && (w_addr == r_addr1)) begin
      r_data1 = w_data;
    end else begin
      r_data1 = regs_q[r_addr1];
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    r_data2 = '0;
    if (!rst_n) begin
      r_data2 = '0;
    end else if (ZERO_REG && (r_addr2 == '0)) begin
      r_data2 = '0;
    end else if (wr_en && (w_addr == r_addr2)) begin
      r_data2 = w_data;
    end else begin
      r_data2 = regs_q[r_addr2];
    end
  end

endmodule

// File: tb/tb_registers_memory.sv
// Scoreboard bench for registers_memory: stimulus pushes expected read data
// into a queue and pulses a sample strobe; a monitor pops and compares.
module tb_registers_memory;

`ifdef REGISTERS_MEMORY_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [4:0]  r_addr1;
  logic [4:0]  r_addr2;
  logic [31:0] r_data1;
  logic [31:0] r_data2;

  registers_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .r_addr1(r_addr1),
    .r_addr2(r_addr2),
    .r_data1(r_data1),
    .r_data2(r_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        chk_tick = 1'b0;
  logic [31:0] ref_mem [32];

  // Reference model of the stored contents.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ref_mem[i] <= 32'd0;
    end else if (wr_en && !(ZERO_REG && (w_addr == 5'd0))) begin
      ref_mem[w_addr] <= w_data;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (ZERO_REG && (a == 5'd0)) return 32'd0;
    if (wr_en && (w_addr == a)) return w_data;
    return ref_mem[a];
  endfunction

  // Monitor: on each sample strobe, drain the scoreboard against the outputs.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_tick);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = (e.port == 1) ? r_data1 : r_data2;
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: r_data%0d got %h expected %h", e.name, e.port, act, e.exp);
        end
      end
    end
  end

  task automatic expect_rd(input string nm, input int port, input logic [31:0] e);
    exp_t x;
    x.name = nm;
    x.port = port;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic settle();
    #1 chk_tick = ~chk_tick;
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; w_addr = 5'd0; w_data = 32'd0;
    r_addr1 = 5'd0; r_addr2 = 5'd7;
    expect_rd("reset_p1", 1, 32'd0);
    expect_rd("reset_p2", 2, 32'd0);
    settle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pre-load r5 then assert reset mid-cycle.
    write_reg(5'd5, 32'hDEADBEEF);
    r_addr1 = 5'd5;
    expect_rd("preload_r5", 1, 32'hDEADBEEF);
    settle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_rd("async_reset_r5", 1, 32'd0);
    settle();
    for (int i = 0; i < 32; i++) begin
      r_addr1 = 5'(i);
      r_addr2 = 5'(31 - i);
      expect_rd("reset_all_p1", 1, 32'd0);
      expect_rd("reset_all_p2", 2, 32'd0);
      settle();
    end
    // Writes and bypass are suppressed while in reset.
    wr_en = 1'b1; w_addr = 5'd5; w_data = 32'h00001111; r_addr1 = 5'd5;
    expect_rd("reset_bypass_blocked", 1, 32'd0);
    settle();
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    expect_rd("reset_write_ignored", 1, 32'd0);
    settle();

    // Basic write/read.
    write_reg(5'd1, 32'd50);
    r_addr2 = 5'd1;
    expect_rd("wr_r1", 2, 32'd50);
    settle();
    write_reg(5'd2, 32'd100);
    write_reg(5'd3, 32'd200);
    r_addr1 = 5'd2; r_addr2 = 5'd3;
    expect_rd("wr_r2", 1, 32'd100);
    expect_rd("wr_r3", 2, 32'd200);
    settle();

    // Register 0 behaviour, during and after the write cycle.
    @(negedge clk);
    wr_en = 1'b1; w_addr = 5'd0; w_data = 32'd25; r_addr1 = 5'd0;
    expect_rd("r0_during_write", 1, ZERO_REG ? 32'd0 : 32'd25);
    settle();
    @(negedge clk);
    wr_en = 1'b0;
    expect_rd("r0_after_write", 1, ZERO_REG ? 32'd0 : 32'd25);
    settle();

    // Write disabled across several edges.
    w_addr = 5'd3; w_data = 32'd7; r_addr1 = 5'd3;
    repeat (3) @(negedge clk);
    expect_rd("wr_disabled_r3", 1, 32'd200);
    settle();

    // Bypass: visible before the edge, persists after it.
    r_addr1 = 5'd4; r_addr2 = 5'd5;
    expect_rd("r4_before", 1, 32'd0);
    settle();
    wr_en = 1'b1; w_addr = 5'd4; w_data = 32'h12345678;
    expect_rd("bypass_before_edge", 1, 32'h12345678);
    expect_rd("bypass_other_port", 2, 32'd0);
    settle();
    @(negedge clk);
    wr_en = 1'b0; w_data = 32'd0;
    expect_rd("bypass_after_edge", 1, 32'h12345678);
    settle();

    // Both ports on the same register.
    r_addr1 = 5'd2; r_addr2 = 5'd2;
    expect_rd("dual_same_p1", 1, 32'd100);
    expect_rd("dual_same_p2", 2, 32'd100);
    settle();

    // Random write/read sequence against the reference array.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      wr_en   = 1'($urandom_range(0, 1));
      w_addr  = 5'($urandom_range(0, 31));
      w_data  = $urandom;
      r_addr1 = (i % 3 == 0) ? w_addr : 5'($urandom_range(0, 31));
      r_addr2 = 5'($urandom_range(0, 31));
      expect_rd("rand_p1", 1, model_read(r_addr1));
      expect_rd("rand_p2", 2, model_read(r_addr2));
      settle();
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i += 4) begin
      r_addr1 = 5'(i);
      r_addr2 = 5'(i + 1);
      expect_rd("final_p1", 1, model_read(r_addr1));
      expect_rd("final_p2", 2, model_read(r_addr2));
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
